alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequential front end for the team's 8-bit 3-bit-opcode combinational ALU.
- Buffers register-to-register instructions from a host in a FIFO and holds a small register file.
- Issues operands and opcode to the ALU, then writes the ALU result back into the register file.
- It is the driving end of the ALU's a/b/opcode/out interface: it produces operands and consumes the result.

Parameters:
DEPTH, 8, instruction FIFO depth in entries; power of 2, at least 2
WIDTH, 8, data width; must equal the ALU operand width
NREG, 4, register-file entries; fixed at 4 because instruction fields are 2-bit

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  host presents an instruction
in_ready  output  1  FIFO not full; push occurs when in_valid && in_ready at the clock edge
in_instr  input  9  instruction: [8:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2
run  input  1  1 = controller may pop and execute; 0 = holds in IDLE after the current instruction retires
reg_we  input  1  host register write
reg_addr  input  2  host write/read address
reg_wdata  input  WIDTH  host write data
reg_rdata  output  WIDTH  combinational read of rf[reg_addr]
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_opcode  output  3  registered opcode to ALU
alu_out  input  WIDTH  ALU result, combinational from alu_a/alu_b/alu_opcode
busy  output  1  state != IDLE, or FIFO non-empty
done  output  1  one-cycle pulse per retired instruction
retired  output  8  retired-instruction count, wraps 255 -> 0
err  output  1  sticky mismatch flag; see Optional Feature

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; state IDLE; all rf entries 0.
  - Outputs: alu_a=0, alu_b=0, alu_opcode=0, done=0, retired=0, err=0, in_ready=1.
  - Reset mid-instruction discards that instruction with no writeback; queued instructions are lost.
- Opcode encoding (ALU-defined, passed through unchanged):
  - 0 add, 1 sub, 2 and, 3 nor, 4 or, 5 nand, 6 xor, 7 not a.
  - Arithmetic is modulo 2^WIDTH; carry/borrow are discarded.
- FIFO:
  - in_ready = !full; it does not depend on a same-cycle pop.
  - Pushes while full are ignored.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, WB.
  - IDLE: if run && !empty, pop into the instruction register and go to EXEC; otherwise stay.
  - EXEC: register alu_a<=rf[rs1], alu_b<=rf[rs2], alu_opcode<=opcode; go to WB.
  - WB: rf[rd]<=alu_out; done pulses in the following cycle; retired increments.
    - If run && !empty: pop the next instruction and go to EXEC.
    - Otherwise go to IDLE.
- Timing and throughput:
  - Steady-state throughput is 1 instruction per 2 cycles.
  - From the push edge into an empty FIFO with IDLE and run=1, writeback occurs at the 3rd following rising edge.
- Hazards: operands are read at EXEC, after the previous WB edge. No forwarding is needed; a back-to-back RAW dependency sees the new value.
- Register-file write contention:
  - Host reg_we and WB to the same address in the same cycle: WB wins and the host write is dropped.
  - Different addresses: both writes happen.
- run deasserted during EXEC or WB: the current instruction completes, then the FSM goes to IDLE.
- alu_a, alu_b and alu_opcode hold their last values outside EXEC/WB.

Optional Feature:
- Macro: ALU_ISSUE_CHECK_EN.
- Defined:
  - An internal model computes the expected result from alu_a, alu_b and alu_opcode, using the encoding above.
  - In WB, if alu_out differs from the expected result, err is set.
  - err is sticky until reset.
- Undefined: err is tied to 0 and no check logic is built.

Test Plan:
- Host writes r0=20, r1=10; push add r2,r0,r1 with run=1 -> at the 3rd edge after the push, rf[2]=30; done pulses once; retired=1.
- Push sub r3,r1,r0, then not r2,r0 -> rf[3]=246 (wrap), rf[2]=235; retired=2; the two done pulses are 2 cycles apart.
- RAW dependency: with r0=20, r1=10, push add r2,r0,r1 then sub r3,r2,r1 back-to-back -> rf[3]=20, not a stale value.
- Full FIFO:
  - With run=0, push 9 instructions into DEPTH=8 -> in_ready drops after the 8th; the 9th is not accepted.
  - Raise run -> exactly 8 instructions retire, retired=8, then busy=0.
- Contention: host reg_we to r2 with wdata 0x55 in the same cycle as WB of add r2 (result 30) -> rf[2]=30.
- Reset mid-op: assert rst during EXEC with 3 instructions queued -> all rf=0, retired=0, in_ready=1, busy=0; no done pulse.
- With ALU_ISSUE_CHECK_EN defined, force a wrong alu_out in the bench during WB -> err=1 and stays 1 until rst.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: FIFO-buffered issue/writeback controller driving an 8-bit combinational ALU.
// Optional result self-check enabled by defining ALU_ISSUE_CHECK_EN.
module alu_issue_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_instr,
    input  logic             run,
    input  logic             reg_we,
    input  logic [1:0]       reg_addr,
    input  logic [WIDTH-1:0] reg_wdata,
    output logic [WIDTH-1:0] reg_rdata,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             done,
    output logic [7:0]       retired,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t           state;
    logic [8:0]       mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic [8:0]       ir;
    logic [WIDTH-1:0] rf [NREG];
    logic             full, empty, push, pop;

    assign full      = cnt == (AW+1)'(DEPTH);
    assign empty     = cnt == '0;
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign pop       = run && !empty && (state == IDLE || state == WB);
    assign busy      = state != IDLE || !empty;
    assign reg_rdata = rf[reg_addr];

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // FIFO storage needs no reset: occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_instr;
    end

    // Issue FSM, register file and registered ALU-side outputs; writeback beats host writes to rd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ir         <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            done       <= 1'b0;
            retired    <= '0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            done <= state == WB;
            if (pop) ir <= mem[rp];
            if (reg_we && !(state == WB && reg_addr == ir[5:4])) rf[reg_addr] <= reg_wdata;
            case (state)
                IDLE: state <= pop ? EXEC : IDLE;
                EXEC: begin
                    alu_a      <= rf[ir[3:2]];
                    alu_b      <= rf[ir[1:0]];
                    alu_opcode <= ir[8:6];
                    state      <= WB;
                end
                WB: begin
                    rf[ir[5:4]] <= alu_out;
                    retired     <= retired + 8'd1;
                    state       <= pop ? EXEC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_CHECK_EN
    logic [WIDTH-1:0] exp_out;

    // Reference model of the ALU encoding, evaluated on the operands currently presented
    always_comb begin
        exp_out = alu_opcode == 3'd0 ? alu_a + alu_b :
                  alu_opcode == 3'd1 ? alu_a - alu_b :
                  alu_opcode == 3'd2 ? alu_a & alu_b :
                  alu_opcode == 3'd3 ? ~(alu_a | alu_b) :
                  alu_opcode == 3'd4 ? alu_a | alu_b :
                  alu_opcode == 3'd5 ? ~(alu_a & alu_b) :
                  alu_opcode == 3'd6 ? alu_a ^ alu_b : ~alu_a;
    end

    // Sticky mismatch flag, sampled only while the ALU result is being written back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (state == WB && alu_out != exp_out) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench for alu_issue_ctrl with a behavioural ALU.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, run, reg_we, busy, done, err;
    logic [8:0] in_instr;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata, alu_a, alu_b, alu_out, retired, corrupt;
    logic [2:0] alu_opcode;
    int         errors = 0, checks = 0;
    int         cyc = 0, done_cnt = 0, last_done = 0, prev_done = 0, base;
    logic       exp_err;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .run(run), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .busy(busy), .done(done), .retired(retired), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return ~(a | b);
            3'd4: return a | b;
            3'd5: return ~(a & b);
            3'd6: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_out = alu_f(alu_a, alu_b, alu_opcode) ^ corrupt;

    always @(negedge clk) begin
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
        end
    end

    function automatic logic [8:0] ins(input int op, input int rd, input int rs1, input int rs2);
        return {3'(op), 2'(rd), 2'(rs1), 2'(rs2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hw(input int a, input int d);
        reg_we = 1'b1; reg_addr = 2'(a); reg_wdata = 8'(d);
        step();
        reg_we = 1'b0;
    endtask

    task automatic push(input logic [8:0] i);
        in_valid = 1'b1; in_instr = i;
        step();
        in_valid = 1'b0;
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        reg_addr = 2'(a);
        #1 d = reg_rdata;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
        repeat (2) step();
    endtask

    logic [7:0] v;

    initial begin
`ifdef ALU_ISSUE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst = 1'b1; in_valid = 0; in_instr = 0; run = 0; reg_we = 0; reg_addr = 0; reg_wdata = 0; corrupt = 0;
        step(); step();
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_op", 32'(alu_opcode), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0; run = 1'b1;
        step();

        hw(0, 20); hw(1, 10);
        push(ins(0, 2, 0, 1));
        step(); step();
        chk("exec_alu_a", 32'(alu_a), 20);
        chk("exec_alu_b", 32'(alu_b), 10);
        chk("exec_alu_op", 32'(alu_opcode), 0);
        rd(2, v); chk("add_before_wb", 32'(v), 0);
        step();
        rd(2, v); chk("add_r2", 32'(v), 30);
        chk("add_done", 32'(done), 1);
        chk("add_retired", 32'(retired), 1);
        step();
        chk("add_done_low", 32'(done), 0);
        chk("add_done_cnt", 32'(done_cnt), 1);

        push(ins(1, 3, 1, 0));
        push(ins(7, 2, 0, 0));
        wait_idle("sub_not_idle");
        rd(3, v); chk("sub_r3_wrap", 32'(v), 246);
        rd(2, v); chk("not_r2", 32'(v), 235);
        chk("sub_not_retired", 32'(retired), 3);
        chk("done_gap", 32'(last_done - prev_done), 2);

        push(ins(0, 2, 0, 1));
        push(ins(1, 3, 2, 1));
        wait_idle("raw_idle");
        rd(2, v); chk("raw_r2", 32'(v), 30);
        rd(3, v); chk("raw_r3", 32'(v), 20);
        chk("raw_retired", 32'(retired), 5);

        run = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_instr = i < 8 ? ins(0, 3, 3, 1) : ins(7, 0, 0, 0);
            #1 chk($sformatf("full_ready_%0d", i), 32'(in_ready), i < 8 ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        chk("full_busy_held", 32'(busy), 1);
        chk("full_retired_held", 32'(retired), 5);
        run = 1'b1;
        wait_idle("full_drain_idle");
        chk("full_retired", 32'(retired), 13);
        rd(3, v); chk("full_r3", 32'(v), 100);
        rd(0, v); chk("full_r0_untouched", 32'(v), 20);
        chk("full_in_ready", 32'(in_ready), 1);

        push(ins(0, 2, 0, 1));
        step(); step();
        reg_we = 1'b1; reg_addr = 2'd2; reg_wdata = 8'h55;
        step();
        reg_we = 1'b0;
        rd(2, v); chk("contention_r2", 32'(v), 30);
        chk("contention_retired", 32'(retired), 14);
        hw(1, 7);
        rd(1, v); chk("host_write_r1", 32'(v), 7);
        hw(1, 10);
        chk("err_clean", 32'(err), 0);
        chk("done_total", 32'(done_cnt), 14);

        run = 1'b0;
        push(ins(0, 2, 0, 1)); push(ins(0, 2, 0, 1)); push(ins(0, 2, 0, 1));
        run = 1'b1;
        step();
        base = done_cnt;
        rst = 1'b1;
        #1;
        rd(0, v); chk("rst_mid_r0", 32'(v), 0);
        rd(1, v); chk("rst_mid_r1", 32'(v), 0);
        rd(2, v); chk("rst_mid_r2", 32'(v), 0);
        chk("rst_mid_retired", 32'(retired), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_mid_no_done", 32'(done_cnt - base), 0);
        chk("rst_mid_busy_after", 32'(busy), 0);
        rd(2, v); chk("rst_mid_r2_after", 32'(v), 0);

        hw(0, 5); hw(1, 3);
        push(ins(0, 2, 0, 1));
        step(); step();
        corrupt = 8'h01;
        step();
        corrupt = 8'h00;
        chk("err_set", 32'(err), 32'(exp_err));
        repeat (3) step();
        chk("err_sticky", 32'(err), 32'(exp_err));
        rst = 1'b1;
        #1 chk("err_cleared", 32'(err), 0);
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
